game_pio_bank: RTL and testbench
================================

// Module: game_pio_bank
// PURPOSE
//  Parametrised multi-channel Avalon-MM PIO bank replacing the separate single-purpose game PIOs
//  (keycodes, score, win/lose, pass-up, LEDs). Adds N input and M output channels, 2-flop input sync,
//  per-channel edge capture with selectable edge mode, maskable IRQ, and atomic set/clear outputs.
//  Sits on the Nios II data bus; the top-level game logic connects to in_port/out_port.
// PARAMETERS
//  N_IN    4   number of input channels (1..8)
//  IN_W    10  bits per input channel (1..32)
//  N_OUT   3   number of output channels (1..8)
//  OUT_W   8   bits per output channel (1..32)
//  OUT_RST 0   reset value loaded into every output channel
// PORTS
//  clk            in   1            system clock; sole clock
//  reset_n        in   1            synchronous, active-low reset
//  avs_address    in   6            {type[2:0], ch[2:0]}
//  avs_read       in   1            read strobe, 1-cycle pulse
//  avs_write      in   1            write strobe, 1-cycle pulse
//  avs_writedata  in   32           write data
//  avs_readdata   out  32           read data; valid the cycle after avs_read
//  irq            out  1            level interrupt to the CPU
//  in_port        in   N_IN*IN_W    asynchronous inputs; channel k is bits [k*IN_W +: IN_W]
//  out_port       out  N_OUT*OUT_W  registered outputs; channel k is bits [k*OUT_W +: OUT_W]
// BEHAVIOUR
//  Reset (reset_n==0 at a clk edge): sync flops, prev, EDGE_CAP, IRQ_MASK=0; EDGE_MODE=00;
//   out regs=OUT_RST; avs_readdata=0; irq=0. Reset mid-operation drops any pending capture or IRQ.
//  Register types (ch = channel index):
//   0 IN_DATA   RO   synchronised input value of channel ch, zero-extended
//   1 EDGE_CAP  W1C  sticky edge bits of channel ch
//   2 IRQ_MASK  RW   per-bit enable ANDed with EDGE_CAP
//   3 EDGE_MODE RW   [1:0]: 00 rising, 01 falling, 10 both, 11 capture disabled
//   4 OUT_DATA  RW   output channel ch
//   5 OUT_SET   WO   out |= wdata; reads return 0
//   6 OUT_CLR   WO   out &= ~wdata; reads return 0
//   7 IRQ_STAT  RO   bit k = |(EDGE_CAP[k] & IRQ_MASK[k]); ch field ignored
//  Channel out of range for its type: reads return 0 and writes are ignored. Bits above IN_W/OUT_W
//   read as 0 and ignore writes.
//  Read latency is 1 cycle. avs_readdata holds its last value while avs_read is low. No wait states.
//  Write latency: the register updates at the clk edge of the write and is visible on the next cycle.
//  Input path: in_port -> s1 -> s2 (sync) -> prev. The edge is prev!=s2, qualified by EDGE_MODE.
//   An input change sampled at edge 0 sets EDGE_CAP at edge 2 and is readable from cycle 3.
//  EDGE_CAP set and W1C on the same bit in the same cycle: the set wins and the bit stays 1.
//  Changing EDGE_MODE does not clear EDGE_CAP.
//  irq = |IRQ_STAT, registered: asserts 1 cycle after the cap/mask bit is set and deasserts 1 cycle
//   after the last pending bit is cleared or masked.
//  Output ops on the same channel in one cycle cannot collide, because the bus allows one write
//   per cycle. out_port is driven directly from the output registers, with no combinational path
//   from the bus.
// STRUCTURE
//  Package game_pio_pkg holds:
//   - localparams for register types TYPE_IN_DATA..TYPE_IRQ_STAT (3-bit)
//   - edge-mode constants EDGE_RISE/EDGE_FALL/EDGE_BOTH/EDGE_OFF
//   - address field widths
//  Sub-module pio_edge_channel #(W) contains sync, prev, edge qualify and the sticky capture with
//   W1C. It is instantiated N_IN times by a generate loop.
//  The top level holds the address decode, mask/mode/output registers, readdata mux and irq flop.
// TESTING
//  1 Reset: OUT_RST=8'hA5, hold reset_n=0 for 2 clk -> out_port all 8'hA5; irq=0; read IN_DATA=0.
//  2 Rising capture: EDGE_MODE[0]=00, mask[0]=1, in ch0 0->10'h001 -> EDGE_CAP[0]=1 readable at
//    cycle 3, irq high at cycle 4; W1C 1 -> irq low 1 cycle later.
//  3 Collision: a new edge on bit 0 in the same cycle as a W1C of bit 0 -> EDGE_CAP[0] stays 1.
//  4 Modes: ch1 mode 01 with pulse 0->1->0 -> exactly one capture; mode 10 -> capture on both
//    edges; mode 11 -> none.
//  5 Outputs: write OUT_DATA ch2=8'h0F, OUT_SET 8'hF0, OUT_CLR 8'h03 -> ch2=8'hFC; read
//    OUT_SET returns 0.
//  6 Range: write/read ch=7 with N_IN=4 -> reads 0, no state change; reset_n=0 while irq is high
//    -> irq=0 next cycle.

Source files
------------

// File: rtl/game_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pio_pkg
// Description : Shared constants for the game PIO bank: register types,
//               edge-capture modes and address field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pio_pkg;

    localparam int TYPE_W = 3;
    localparam int CH_W   = 3;
    localparam int ADDR_W = TYPE_W + CH_W;
    localparam int DATA_W = 32;

    localparam logic [TYPE_W-1:0] TYPE_IN_DATA   = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_EDGE_CAP  = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_IRQ_MASK  = 3'd2;
    localparam logic [TYPE_W-1:0] TYPE_EDGE_MODE = 3'd3;
    localparam logic [TYPE_W-1:0] TYPE_OUT_DATA  = 3'd4;
    localparam logic [TYPE_W-1:0] TYPE_OUT_SET   = 3'd5;
    localparam logic [TYPE_W-1:0] TYPE_OUT_CLR   = 3'd6;
    localparam logic [TYPE_W-1:0] TYPE_IRQ_STAT  = 3'd7;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/game_pio_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : game_pio_bank_if
// Description : Avalon-MM slave bus bundle (plus level interrupt) for the
//               game PIO bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_pio_bank_if
    import game_pio_pkg::*;
;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic              irq;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );

endinterface
`default_nettype wire

// File: rtl/game_pio_bank_edge_channel.sv
`default_nettype none
// ============================================================================
// Module      : pio_edge_channel
// Description : One input channel: 2-flop synchroniser, previous-value flop,
//               edge qualification and sticky W1C edge capture.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_edge_channel
    import game_pio_pkg::*;
#(
    parameter int W = 10
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic [W-1:0] i_din,
    input  wire logic [1:0]   i_mode,
    input  wire logic         i_w1c_en,
    input  wire logic [W-1:0] i_w1c_bits,
    output logic      [W-1:0] o_sync,
    output logic      [W-1:0] o_cap
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_prev;
    logic [W-1:0] r_cap;
    logic [W-1:0] w_rise;
    logic [W-1:0] w_fall;
    logic [W-1:0] w_edge;
    logic [W-1:0] w_clr;

    assign w_rise = r_s2 & ~r_prev;
    assign w_fall = ~r_s2 & r_prev;
    assign w_clr  = i_w1c_en ? i_w1c_bits : '0;

    always_comb begin
        w_edge = '0;
        case (i_mode)
            EDGE_RISE: w_edge = w_rise;
            EDGE_FALL: w_edge = w_fall;
            EDGE_BOTH: w_edge = w_rise | w_fall;
            default:   w_edge = '0;
        endcase
    end

    // New edges are ORed in after the clear, so a coincident set wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_cap  <= '0;
        end else begin
            r_s1   <= i_din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_cap  <= (r_cap & ~w_clr) | w_edge;
        end
    end

    assign o_sync = r_s2;
    assign o_cap  = r_cap;

endmodule
`default_nettype wire

// File: rtl/game_pio_bank.sv
`default_nettype none
// ============================================================================
// Module      : game_pio_bank
// Description : Multi-channel Avalon-MM PIO bank with edge capture, maskable
//               interrupt and atomic set/clear output channels.
// Revision    : 1.0 - initial release
// ============================================================================
module game_pio_bank
    import game_pio_pkg::*;
#(
    parameter int               N_IN    = 4,
    parameter int               IN_W    = 10,
    parameter int               N_OUT   = 3,
    parameter int               OUT_W   = 8,
    parameter logic [OUT_W-1:0] OUT_RST = '0
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    game_pio_bank_if.slave              avs,
    input  wire logic [N_IN*IN_W-1:0]   in_port,
    output logic      [N_OUT*OUT_W-1:0] out_port
);

    logic [TYPE_W-1:0] w_type;
    logic [CH_W-1:0]   w_ch;
    logic [IN_W-1:0]   w_sync [N_IN];
    logic [IN_W-1:0]   w_cap  [N_IN];
    logic [N_IN-1:0]   w_stat;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_wdata;

    logic [IN_W-1:0]   r_mask [N_IN];
    logic [1:0]        r_mode [N_IN];
    logic [OUT_W-1:0]  r_out  [N_OUT];
    logic [DATA_W-1:0] r_readdata;
    logic              r_irq;

    assign w_type         = avs.avs_address[ADDR_W-1:CH_W];
    assign w_ch           = avs.avs_address[CH_W-1:0];
    assign w_unused_wdata = ^avs.avs_writedata;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        logic w_w1c_en;

        assign w_w1c_en = avs.avs_write && (w_type == TYPE_EDGE_CAP) && (w_ch == 3'(k));

        pio_edge_channel #(.W(IN_W)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_din      (in_port[k*IN_W +: IN_W]),
            .i_mode     (r_mode[k]),
            .i_w1c_en   (w_w1c_en),
            .i_w1c_bits (avs.avs_writedata[IN_W-1:0]),
            .o_sync     (w_sync[k]),
            .o_cap      (w_cap[k])
        );

        assign w_stat[k] = |(w_cap[k] & r_mask[k]);
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_port[k*OUT_W +: OUT_W] = r_out[k];
    end

    // Out-of-range channels never match the loop index, so they are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_IN; k++) begin
                r_mask[k] <= '0;
                r_mode[k] <= EDGE_RISE;
            end
            for (int k = 0; k < N_OUT; k++) begin
                r_out[k] <= OUT_RST;
            end
        end else if (avs.avs_write) begin
            for (int k = 0; k < N_IN; k++) begin
                if (w_ch == 3'(k)) begin
                    if (w_type == TYPE_IRQ_MASK)  r_mask[k] <= avs.avs_writedata[IN_W-1:0];
                    if (w_type == TYPE_EDGE_MODE) r_mode[k] <= avs.avs_writedata[1:0];
                end
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (w_ch == 3'(k)) begin
                    case (w_type)
                        TYPE_OUT_DATA: r_out[k] <= avs.avs_writedata[OUT_W-1:0];
                        TYPE_OUT_SET:  r_out[k] <= r_out[k] | avs.avs_writedata[OUT_W-1:0];
                        TYPE_OUT_CLR:  r_out[k] <= r_out[k] & ~avs.avs_writedata[OUT_W-1:0];
                        default:       r_out[k] <= r_out[k];
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (w_ch == 3'(k)) begin
                case (w_type)
                    TYPE_IN_DATA:   w_rdata = DATA_W'(w_sync[k]);
                    TYPE_EDGE_CAP:  w_rdata = DATA_W'(w_cap[k]);
                    TYPE_IRQ_MASK:  w_rdata = DATA_W'(r_mask[k]);
                    TYPE_EDGE_MODE: w_rdata = DATA_W'(r_mode[k]);
                    default:        ;
                endcase
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if ((w_ch == 3'(k)) && (w_type == TYPE_OUT_DATA)) begin
                w_rdata = DATA_W'(r_out[k]);
            end
        end
        if (w_type == TYPE_IRQ_STAT) begin
            w_rdata = DATA_W'(w_stat);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (avs.avs_read) r_readdata <= w_rdata;
            r_irq <= |w_stat;
        end
    end

    assign avs.avs_readdata = r_readdata;
    assign avs.irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_game_pio_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_pio_bank
// Description : Scoreboard bench for game_pio_bank; reads queue an expected
//               value, a monitor pops and compares one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_pio_bank;
    import game_pio_pkg::*;

    localparam int         N_IN    = 4;
    localparam int         IN_W    = 10;
    localparam int         N_OUT   = 3;
    localparam int         OUT_W   = 8;
    localparam logic [7:0] OUT_RST = 8'hA5;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_IN*IN_W-1:0]   in_port;
    logic [N_OUT*OUT_W-1:0] out_port;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    string       name_q[$];
    logic        rd_d = 1'b0;

    game_pio_bank_if bus ();

    game_pio_bank #(
        .N_IN    (N_IN),
        .IN_W    (IN_W),
        .N_OUT   (N_OUT),
        .OUT_W   (OUT_W),
        .OUT_RST (OUT_RST)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus),
        .in_port  (in_port),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_d <= bus.avs_read;

    // Monitor: readdata is valid the cycle after the read strobe.
    always @(negedge clk) begin
        logic [31:0] e;
        string       nm;
        if (rd_d) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %h, nothing expected", bus.avs_readdata);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.avs_readdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", nm, bus.avs_readdata, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] t, input logic [2:0] ch, input logic [31:0] d);
        bus.avs_address   = {t, ch};
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] t, input logic [2:0] ch, input logic [31:0] e,
                      input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.avs_address = {t, ch};
        bus.avs_read    = 1'b1;
        tick();
        bus.avs_read    = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, e);
        end
    endtask

    task automatic set_in(input int ch, input logic [IN_W-1:0] v);
        in_port[ch*IN_W +: IN_W] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        in_port           = '0;

        // Reset values
        reset_n = 1'b0;
        tick(2);
        chk("rst_out_port", 64'(out_port), 64'({3{8'hA5}}));
        chk("rst_irq", 64'(bus.irq), 64'd0);
        reset_n = 1'b1;
        rd(TYPE_IN_DATA, 3'd0, 32'd0, "rst_in_data");
        rd(TYPE_EDGE_MODE, 3'd0, 32'd0, "rst_edge_mode");

        // Rising capture and interrupt timing on ch0
        wr(TYPE_IRQ_MASK, 3'd0, 32'h0000_03FF);
        wr(TYPE_EDGE_MODE, 3'd0, 32'd0);
        set_in(0, 10'h001);
        tick(2);
        rd(TYPE_EDGE_CAP, 3'd0, 32'd0, "cap_not_yet_at_edge2");
        chk("irq_low_before_cap", 64'(bus.irq), 64'd0);
        rd(TYPE_EDGE_CAP, 3'd0, 32'd1, "cap_readable_cycle3");
        chk("irq_high_after_cap", 64'(bus.irq), 64'd1);
        rd(TYPE_IN_DATA, 3'd0, 32'd1, "in_data_sync");
        rd(TYPE_IRQ_STAT, 3'd5, 32'd1, "irq_stat_ch_ignored");
        wr(TYPE_EDGE_CAP, 3'd0, 32'd1);
        chk("irq_still_high_w1c_cycle", 64'(bus.irq), 64'd1);
        tick();
        chk("irq_low_after_w1c", 64'(bus.irq), 64'd0);

        // Set beats W1C on the same cycle
        set_in(0, 10'h000);
        tick(4);
        rd(TYPE_EDGE_CAP, 3'd0, 32'd0, "rise_mode_ignores_fall");
        set_in(0, 10'h001);
        tick(2);
        wr(TYPE_EDGE_CAP, 3'd0, 32'd1);
        rd(TYPE_EDGE_CAP, 3'd0, 32'd1, "collision_set_wins");
        wr(TYPE_EDGE_CAP, 3'd0, 32'hFFFF_FFFF);
        rd(TYPE_EDGE_CAP, 3'd0, 32'd0, "w1c_clears");

        // Edge modes on ch1
        wr(TYPE_EDGE_MODE, 3'd1, 32'd1);
        rd(TYPE_EDGE_MODE, 3'd1, 32'd1, "mode_readback");
        set_in(1, 10'h001);
        tick(4);
        rd(TYPE_EDGE_CAP, 3'd1, 32'd0, "fall_mode_ignores_rise");
        set_in(1, 10'h000);
        tick(4);
        rd(TYPE_EDGE_CAP, 3'd1, 32'd1, "fall_mode_capture");
        wr(TYPE_EDGE_CAP, 3'd1, 32'd1);
        wr(TYPE_EDGE_MODE, 3'd1, 32'd2);
        set_in(1, 10'h008);
        tick(4);
        rd(TYPE_EDGE_CAP, 3'd1, 32'h8, "both_mode_rise");
        wr(TYPE_EDGE_CAP, 3'd1, 32'h8);
        set_in(1, 10'h000);
        tick(4);
        rd(TYPE_EDGE_CAP, 3'd1, 32'h8, "both_mode_fall");
        wr(TYPE_EDGE_CAP, 3'd1, 32'hFFFF_FFFF);
        wr(TYPE_EDGE_MODE, 3'd1, 32'hFFFF_FFFF);
        rd(TYPE_EDGE_MODE, 3'd1, 32'd3, "mode_upper_bits_ignored");
        set_in(1, 10'h3FF);
        tick(4);
        set_in(1, 10'h000);
        tick(4);
        rd(TYPE_EDGE_CAP, 3'd1, 32'd0, "off_mode_no_capture");

        // Mode change keeps captured bits
        set_in(2, 10'h200);
        tick(4);
        wr(TYPE_EDGE_MODE, 3'd2, 32'd3);
        rd(TYPE_EDGE_CAP, 3'd2, 32'h200, "mode_change_keeps_cap");

        // Output channel operations
        wr(TYPE_OUT_DATA, 3'd2, 32'h0F);
        wr(TYPE_OUT_SET, 3'd2, 32'hF0);
        wr(TYPE_OUT_CLR, 3'd2, 32'h03);
        chk("out_port_set_clr", 64'(out_port), 64'({8'hFC, 8'hA5, 8'hA5}));
        rd(TYPE_OUT_DATA, 3'd2, 32'hFC, "out_data_readback");
        rd(TYPE_OUT_SET, 3'd2, 32'd0, "out_set_reads_zero");
        rd(TYPE_OUT_CLR, 3'd2, 32'd0, "out_clr_reads_zero");
        wr(TYPE_OUT_DATA, 3'd1, 32'h1FF);
        rd(TYPE_OUT_DATA, 3'd1, 32'hFF, "out_width_truncate");
        set_in(3, 10'h3FF);
        tick(3);
        rd(TYPE_IN_DATA, 3'd3, 32'h3FF, "in_data_zero_extend");

        // Out-of-range channels
        wr(TYPE_IRQ_MASK, 3'd7, 32'hFFFF_FFFF);
        rd(TYPE_IRQ_MASK, 3'd7, 32'd0, "range_mask_ch7");
        rd(TYPE_IN_DATA, 3'd7, 32'd0, "range_in_ch7");
        rd(TYPE_OUT_DATA, 3'd3, 32'd0, "range_out_ch3");
        wr(TYPE_OUT_DATA, 3'd5, 32'hFF);
        chk("range_out_write_ignored", 64'(out_port), 64'({8'hFC, 8'hFF, 8'hA5}));
        rd(TYPE_IRQ_STAT, 3'd0, 32'd0, "range_no_irq_stat");

        // Reset while irq is high
        wr(TYPE_IRQ_MASK, 3'd3, 32'h3FF);
        set_in(3, 10'h000);
        tick(4);
        set_in(3, 10'h001);
        tick(4);
        rd(TYPE_IRQ_STAT, 3'd0, 32'h8, "irq_stat_ch3");
        chk("irq_high_before_reset", 64'(bus.irq), 64'd1);
        reset_n = 1'b0;
        tick();
        chk("irq_cleared_by_reset", 64'(bus.irq), 64'd0);
        chk("out_port_after_reset", 64'(out_port), 64'({3{8'hA5}}));
        reset_n = 1'b1;
        rd(TYPE_EDGE_CAP, 3'd3, 32'd0, "cap_cleared_by_reset");
        rd(TYPE_IRQ_MASK, 3'd3, 32'd0, "mask_cleared_by_reset");

        tick(2);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
